fifo_rd_ctrl_prog: RTL

Read-domain controller for the async FIFO, parametrised successor of the current read-side pointer block. It has the same Gray-pointer / empty-flag core plus four additions: configurable synchronizer depth, a registered occupancy count, a programmable almost-empty threshold and a sticky underflow flag. It sits in the r_clk domain between the dual-port RAM read port and the consumer, and exchanges Gray pointers with the write-domain controller.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/binary_to_gray.sv | 19 +
 rtl/gray_to_binary.sv | 22 ++
 rtl/multi_ff_synchronizer.sv | 37 +++
 rtl/fifo_rd_ctrl_prog.sv | 99 +++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// ============================================================================
// Module   : fifo_pkg
// Brief    : Shared constants and Gray/binary helpers for the async FIFO.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

package fifo_pkg;

  localparam int c_SYNC_STAGES_MIN = 2;
  localparam int c_SYNC_STAGES_MAX = 4;

  function automatic logic [31:0] bin2gray(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int i = 1; i < 32; i++) begin
      bin = bin ^ (gray >> i);
    end
    return bin;
  endfunction

endpackage

`default_nettype wire

// File: rtl/binary_to_gray.sv
// ============================================================================
// Module   : binary_to_gray
// Brief    : Combinational N-bit binary to Gray code converter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_to_gray #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_bin,
  output logic [N-1:0] o_gray
);

  assign o_gray = i_bin ^ (i_bin >> 1);

endmodule

`default_nettype wire

// File: rtl/gray_to_binary.sv
// ============================================================================
// Module   : gray_to_binary
// Brief    : Combinational N-bit Gray to binary converter (XOR prefix).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_to_binary #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_gray,
  output logic [N-1:0] o_bin
);

  // Each binary bit is the XOR of all Gray bits at or above it.
  for (genvar i = 0; i < N; i++) begin : g_bit
    assign o_bin[i] = ^i_gray[N-1:i];
  end

endmodule

`default_nettype wire

// File: rtl/multi_ff_synchronizer.sv
// ============================================================================
// Module   : multi_ff_synchronizer
// Brief    : STAGES-deep flop chain carrying a SIZE-bit bus into clk domain.
// Revision : 1.0 - generalised from the two-flop synchronizer
// ============================================================================
`default_nettype none

module multi_ff_synchronizer #(
  parameter int SIZE   = 5,
  parameter int STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] i_d,
  output logic [SIZE-1:0] o_q
);

  logic [SIZE-1:0] r_chain [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/fifo_rd_ctrl_prog.sv
// ============================================================================
// Module   : fifo_rd_ctrl_prog
// Brief    : Async FIFO read-side controller with occupancy, programmable
//            almost-empty threshold and sticky underflow.
// Revision : 1.0 - initial parametrised release
// ============================================================================
`default_nettype none

module fifo_rd_ctrl_prog
  import fifo_pkg::*;
#(
  parameter int ADDRESS_SIZE   = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int AE_RESET_LEVEL = 1
) (
  input  logic                  r_clk,
  input  logic                  rrst_n,
  input  logic                  r_en,
  input  logic [ADDRESS_SIZE:0] w_ptr,
  input  logic [ADDRESS_SIZE:0] r_ae_level,
  input  logic                  r_ae_load,
  input  logic                  r_uf_clr,
  output logic [ADDRESS_SIZE:0] r_ptr,
  output logic [ADDRESS_SIZE-1:0] r_addr,
  output logic                  r_empty,
  output logic                  r_almost_empty,
  output logic [ADDRESS_SIZE:0] r_level,
  output logic                  r_underflow
);

  localparam int c_AW = ADDRESS_SIZE;
  // Out-of-range synchronizer depths are pulled into the supported range.
  localparam int c_STAGES = (SYNC_STAGES < c_SYNC_STAGES_MIN) ? c_SYNC_STAGES_MIN :
                            (SYNC_STAGES > c_SYNC_STAGES_MAX) ? c_SYNC_STAGES_MAX :
                            SYNC_STAGES;
  localparam logic [c_AW:0] c_AE_RESET = AE_RESET_LEVEL[c_AW:0];

  logic [c_AW:0] r_bin;
  logic [c_AW:0] r_ae_thr;
  logic [c_AW:0] w_bnext;
  logic [c_AW:0] w_gnext;
  logic [c_AW:0] w_wq_ptr;
  logic [c_AW:0] w_wq_bin;
  logic [c_AW:0] w_lvl_next;
  logic          w_rd_acc;

  assign w_rd_acc = r_en & ~r_empty;
  assign w_bnext  = r_bin + {{c_AW{1'b0}}, w_rd_acc};
  assign r_addr   = r_bin[c_AW-1:0];

  binary_to_gray #(.N(c_AW + 1)) u_b2g (
    .i_bin  (w_bnext),
    .o_gray (w_gnext)
  );

  multi_ff_synchronizer #(.SIZE(c_AW + 1), .STAGES(c_STAGES)) u_wptr_sync (
    .clk   (r_clk),
    .rst_n (rrst_n),
    .i_d   (w_ptr),
    .o_q   (w_wq_ptr)
  );

  gray_to_binary #(.N(c_AW + 1)) u_g2b (
    .i_gray (w_wq_ptr),
    .o_bin  (w_wq_bin)
  );

  // Uses the post-read pointer, so a lagging write view only understates.
  assign w_lvl_next = w_wq_bin - w_bnext;

  always_ff @(posedge r_clk) begin
    if (!rrst_n) begin
      r_bin          <= '0;
      r_ptr          <= '0;
      r_empty        <= 1'b1;
      r_almost_empty <= 1'b1;
      r_level        <= '0;
      r_underflow    <= 1'b0;
      r_ae_thr       <= c_AE_RESET;
    end else begin
      r_bin          <= w_bnext;
      r_ptr          <= w_gnext;
      r_empty        <= (w_gnext == w_wq_ptr);
      r_level        <= w_lvl_next;
      r_almost_empty <= (w_lvl_next <= r_ae_thr);
      if (r_ae_load) begin
        r_ae_thr <= r_ae_level;
      end
      if (r_en && r_empty) begin
        r_underflow <= 1'b1;
      end else if (r_uf_clr) begin
        r_underflow <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire
